// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the iterative divider.
// Holds the FSM state encoding and the default operand width / iteration count.
// Imported by the interface, the iteration step and the top.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_if.sv
// div_if: request/result bundle between a divide requester and div_unit.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the divider reports idle.
// Ports: master drives start/is_signed/dividend/divisor and observes
//        busy/done/quotient/remainder/overflow/div_by_zero; slave is the divider.
interface div_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, overflow, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, overflow, div_by_zero
  );

endinterface

// File: rtl/div_sub_step.sv
// div_sub_step: one restoring-division iteration on unsigned magnitudes.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rem/quo = current partial remainder and quotient shift register,
//        dmag = divisor magnitude; rem_nx/quo_nx = values after this iteration.
module div_sub_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);

  // One extra bit so the shifted remainder never wraps before the compare.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dmag};
    fits    = (shifted >= {1'b0, dmag});
    // Invariant rem < dmag keeps the kept difference inside WIDTH bits.
    rem_nx  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nx  = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider, signed (DIV) or unsigned (DIVU).
// Latency: start accepted at edge E, done sampled high at edge E+ITERS+2; one op per ITERS+3 cycles.
// Backpressure: start is ignored unless idle; done is a one-cycle pulse, results held until next start.
// Ports: clk, rst_n (async, active-low); bus (div_if.slave) carries the request
//        operands, busy/done status, quotient, remainder and the overflow / div_by_zero flags.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITERS = DIV_ITERS
) (
  input  logic  clk,
  input  logic  rst_n,
  div_if.slave  bus
);

  localparam int             CW      = $clog2(ITERS + 1);
  localparam logic [CW-1:0]  ITERS_C = CW'(ITERS);

  state_t           state;
  state_t           state_nx;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dmag_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             dz_r;
  logic             ovf_r;

  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             overflow_r;
  logic             div_by_zero_r;

  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // Operand sign/magnitude decode at the request boundary.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;

  always_comb begin
    a_neg  = bus.is_signed & bus.dividend[WIDTH-1];
    b_neg  = bus.is_signed & bus.divisor[WIDTH-1];
    // The most negative value negates to itself, which read as unsigned is its true magnitude.
    a_mag  = a_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    b_mag  = b_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    accept = (state == IDLE) & bus.start;
  end

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .rem    (rem_r),
    .quo    (quo_r),
    .dmag   (dmag_r),
    .rem_nx (rem_nx),
    .quo_nx (quo_nx)
  );

  assign cnt_inc = cnt + 1'b1;

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CALC;
      CALC:    if (cnt_inc == ITERS_C) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath: latch on accept, iterate in CALC, sign-fix into the held outputs in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      rem_r         <= '0;
      quo_r         <= '0;
      dmag_r        <= '0;
      neg_q_r       <= 1'b0;
      neg_r_r       <= 1'b0;
      dz_r          <= 1'b0;
      ovf_r         <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      overflow_r    <= 1'b0;
      div_by_zero_r <= 1'b0;
    end else begin
      if (accept) begin
        cnt           <= '0;
        rem_r         <= '0;
        quo_r         <= a_mag;
        dmag_r        <= b_mag;
        neg_q_r       <= a_neg ^ b_neg;
        neg_r_r       <= a_neg;
        dz_r          <= (bus.divisor == '0);
        ovf_r         <= bus.is_signed
                         && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                         && (bus.divisor == '1);
        quotient_r    <= '0;
        remainder_r   <= '0;
        overflow_r    <= 1'b0;
        div_by_zero_r <= 1'b0;
      end else if (state == CALC) begin
        rem_r <= rem_nx;
        quo_r <= quo_nx;
        cnt   <= cnt_inc;
      end else if (state == FIX) begin
        // A zero divisor yields an all-ones magnitude quotient; force it so the
        // signed path does not negate it away.
        if (dz_r) begin
          quotient_r <= '1;
        end else if (neg_q_r) begin
          quotient_r <= ~quo_r + 1'b1;
        end else begin
          quotient_r <= quo_r;
        end
        remainder_r   <= neg_r_r ? (~rem_r + 1'b1) : rem_r;
        overflow_r    <= ovf_r;
        div_by_zero_r <= dz_r;
      end
    end
  end

  // busy and done decode disjoint states, so they can never overlap.
  assign bus.busy        = (state == CALC) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.overflow    = overflow_r;
  assign bus.div_by_zero = div_by_zero_r;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand, quotient and remainder width.
REQ-002 Parameter ITERS, default WIDTH: number of quotient-bit iterations.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a divide; sampled only in IDLE.
REQ-006 is_signed  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-007 dividend  input  WIDTH  numerator; sampled with start.
REQ-008 divisor  input  WIDTH  denominator; sampled with start.
REQ-009 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-010 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-011 quotient  output  WIDTH  LO result; held until the next accepted start.
REQ-012 remainder  output  WIDTH  HI result; held until the next accepted start.
REQ-013 overflow  output  1  signed MIN/-1 flag; held with the results.
REQ-014 div_by_zero  output  1  divisor==0 flag; held with the results.

Function
REQ-015 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
REQ-016 IDLE with start=1 at edge E SHALL latch the operands and is_signed and go to CALC.
REQ-017 On latch, the block SHALL clear the held outputs and flags.
REQ-018 On latch, the block SHALL store operand magnitudes: absolute value if is_signed, raw value otherwise.
REQ-019 CALC SHALL run exactly ITERS restoring iterations, one per cycle.
REQ-020 Each iteration: shift {rem,quo} left 1, trial-subtract the divisor magnitude, keep the difference if non-negative and set the quotient LSB, else restore.
REQ-021 The iteration counter SHALL be $clog2(ITERS+1) bits; CALC SHALL leave when it reaches ITERS.
REQ-022 FIX (1 cycle): negate quotient if signs differ (signed); negate remainder if dividend negative (signed); write outputs.
REQ-023 DONE (1 cycle): assert done and return to IDLE; total latency start-edge E to done high = ITERS+2 cycles (34 at default), fixed for all operands.
REQ-024 Signed results SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign; |remainder| < |divisor|.
REQ-025 Divisor=0: quotient=all ones, remainder=dividend, div_by_zero=1, overflow=0; latency unchanged.
REQ-026 Signed 2^(WIDTH-1) / -1: quotient=0x80000000, remainder=0, overflow=1; latency unchanged.
REQ-027 Magnitude of the most negative value SHALL be handled as an unsigned WIDTH-bit value, with no internal overflow.
REQ-028 start while busy or in DONE SHALL be ignored, with no effect on the in-flight operation.
REQ-029 start in the cycle after done (IDLE) SHALL be accepted; back-to-back throughput is one op per ITERS+3 cycles.
REQ-030 done and busy SHALL never be high in the same cycle.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, including mid-CALC/FIX; the in-flight operation is discarded.
REQ-032 rst_n=0 SHALL asynchronously clear busy, done, quotient, remainder, overflow, div_by_zero and all internal registers.
REQ-033 After rst_n deasserts, the first rising edge SHALL evaluate start normally.

Structure
REQ-034 The shared package div_pkg SHALL hold the FSM state enum, the WIDTH default and the ITERS default.
REQ-035 One combinational sub-module div_sub_step (one restoring iteration: inputs rem, quo, divisor magnitude; outputs next rem, next quo) SHALL be instantiated once.
REQ-036 Sign handling, the counter and the FSM SHALL stay in div_unit.

Verification
REQ-037 Signed 100/7: start at edge E -> done at E+34, quotient=14, remainder=2, flags 0.
REQ-038 Signed -100/7: quotient=0xFFFFFFF2, remainder=0xFFFFFFFE; unsigned 0xFFFFFFFF/2: quotient=0x7FFFFFFF, remainder=1.
REQ-039 Signed 0x80000000/0xFFFFFFFF: quotient=0x80000000, remainder=0, overflow=1, at E+34.
REQ-040 5/0 (either mode): quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, at E+34.
REQ-041 Reset mid-op: assert rst_n=0 ten cycles after start -> busy, done and all outputs 0 immediately; a new 9/3 then yields quotient=3, remainder=0.
REQ-042 start pulsed at E+5 during 100/7 -> ignored, result 14/2 unchanged; start at the cycle after done -> accepted, busy next cycle.
